// File: rtl/hazard_scoreboard.sv
// Purpose : D-stage hazard scheduler for the 5-stage MIPS pipeline (stall, forwarding selects, stall counter).
// Latency : stall and forwarding selects are combinational from the D inputs and the E/M/W slots; slots advance every edge.
// Backpres: stall freezes PC and IF/ID and turns the instruction entering E into a bubble; no other flow control.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-low reset
//   d_valid            D stage holds a real instruction (0 = bubble)
//   d_rs, d_rt         D-stage source register numbers
//   d_tuse_rs/rt       cycles until the D instruction needs each operand (>= 3 means unused)
//   d_regw, d_dst      D instruction writes register d_dst
//   d_tnew             cycles after entering E until the D instruction's result can be forwarded
//   stall              hold PC and IF/ID, bubble into ID/EX
//   fwd_d_rs/rt        D operand source: 0 = RF, 1 = E, 2 = M, 3 = W
//   fwd_e_rs/rt        E operand source: 0 = pipeline reg, 1 = M, 2 = W
//   stall_cnt          number of stalled cycles, wraps

module hazard_scoreboard #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic [2:0]       d_tuse_rs,
    input  logic [2:0]       d_tuse_rt,
    input  logic             d_regw,
    input  logic [4:0]       d_dst,
    input  logic [2:0]       d_tnew,
    output logic             stall,
    output logic [1:0]       fwd_d_rs,
    output logic [1:0]       fwd_d_rt,
    output logic [1:0]       fwd_e_rs,
    output logic [1:0]       fwd_e_rt,
    output logic [CNT_W-1:0] stall_cnt
);

    // One in-flight register writer: write-valid, destination, cycles until forwardable.
    typedef struct packed {
        logic       w;
        logic [4:0] dst;
        logic [2:0] tnew;
    } slot_t;

    localparam logic [1:0] D_SRC_RF = 2'd0;
    localparam logic [1:0] D_SRC_E  = 2'd1;
    localparam logic [1:0] D_SRC_M  = 2'd2;
    localparam logic [1:0] D_SRC_W  = 2'd3;

    localparam logic [1:0] E_SRC_PIPE = 2'd0;
    localparam logic [1:0] E_SRC_M    = 2'd1;
    localparam logic [1:0] E_SRC_W    = 2'd2;

    slot_t      e_slot;
    slot_t      m_slot;
    slot_t      w_slot;
    logic [4:0] e_rs;
    logic [4:0] e_rt;

    // Writers to $0 never match anything, so $0 never stalls and never forwards.
    function automatic logic slot_match(input slot_t s, input logic [4:0] r);
        return s.w && (s.dst == r) && (r != 5'd0);
    endfunction

    function automatic logic [2:0] sat_dec(input logic [2:0] t);
        return (t == 3'd0) ? 3'd0 : t - 3'd1;
    endfunction

    // Only E and M can still be computing; a W writer's value is always in hand.
    function automatic logic src_hazard(input slot_t e, input slot_t m,
                                        input logic [4:0] r, input logic [2:0] tuse);
        logic hz;
        hz = 1'b0;
        if (slot_match(e, r) && (e.tnew > tuse)) begin
            hz = 1'b1;
        end
        if (slot_match(m, r) && (m.tnew > tuse)) begin
            hz = 1'b1;
        end
        return hz;
    endfunction

    // Youngest matching writer decides. If it is still computing, fall back to the
    // register file rather than forwarding a stale value from an older slot; the
    // consumer is either stalled or does not need the operand yet.
    function automatic logic [1:0] d_src_sel(input slot_t e, input slot_t m, input slot_t w,
                                             input logic [4:0] r);
        logic [1:0] sel;
        sel = D_SRC_RF;
        if (slot_match(e, r)) begin
            sel = (e.tnew == 3'd0) ? D_SRC_E : D_SRC_RF;
        end else if (slot_match(m, r)) begin
            sel = (m.tnew == 3'd0) ? D_SRC_M : D_SRC_RF;
        end else if (slot_match(w, r)) begin
            sel = (w.tnew == 3'd0) ? D_SRC_W : D_SRC_RF;
        end
        return sel;
    endfunction

    // E operands only look at M and W. A pending M writer blocks forwarding from W.
    function automatic logic [1:0] e_src_sel(input slot_t m, input slot_t w,
                                             input logic [4:0] r);
        logic [1:0] sel;
        sel = E_SRC_PIPE;
        if (slot_match(m, r)) begin
            sel = (m.tnew == 3'd0) ? E_SRC_M : E_SRC_PIPE;
        end else if (slot_match(w, r)) begin
            sel = E_SRC_W;
        end
        return sel;
    endfunction

    logic stall_rs;
    logic stall_rt;
    logic d_issue;

    always_comb begin
        stall_rs = src_hazard(e_slot, m_slot, d_rs, d_tuse_rs);
        stall_rt = src_hazard(e_slot, m_slot, d_rt, d_tuse_rt);
        stall    = d_valid && (stall_rs || stall_rt);
        d_issue  = d_valid && !stall;

        fwd_d_rs = d_src_sel(e_slot, m_slot, w_slot, d_rs);
        fwd_d_rt = d_src_sel(e_slot, m_slot, w_slot, d_rt);
        fwd_e_rs = e_src_sel(m_slot, w_slot, e_rs);
        fwd_e_rt = e_src_sel(m_slot, w_slot, e_rt);
    end

    // Slot pipeline: every edge each writer moves one stage and its countdown drops by one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_slot <= '0;
            m_slot <= '0;
            w_slot <= '0;
            e_rs   <= 5'd0;
            e_rt   <= 5'd0;
        end else begin
            w_slot <= '{w: m_slot.w, dst: m_slot.dst, tnew: sat_dec(m_slot.tnew)};
            m_slot <= '{w: e_slot.w, dst: e_slot.dst, tnew: sat_dec(e_slot.tnew)};

            if (d_issue && d_regw) begin
                e_slot <= '{w: 1'b1, dst: d_dst, tnew: d_tnew};
            end else begin
                e_slot <= '0;
            end

            // Source copies follow every issued instruction, writer or not, so
            // stores and branches in E still get their operands forwarded.
            e_rs <= d_issue ? d_rs : 5'd0;
            e_rt <= d_issue ? d_rt : 5'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Hazard scheduler for the 5-stage MIPS pipeline.
- Tracks in-flight register writers in E/M/W shadow slots, each with a countdown of cycles until its result is ready (tnew).
- Compares tnew against the D-stage decoder's per-operand T_use. Drives the D-stage stall (freeze PC/IF-ID, bubble into E) and forwarding mux selects for D and E operands.
- Also keeps a stall-cycle performance counter.

Parameters:
CNT_W, 16, width of stall performance counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
d_valid  input  1  D-stage holds a real instruction (0 = bubble)
d_rs  input  5  D-stage rs field
d_rt  input  5  D-stage rt field
d_tuse_rs  input  3  cycles until D instr needs rs (0..2 used; >=3 means not used)
d_tuse_rt  input  3  same for rt
d_regw  input  1  D instr writes a register
d_dst  input  5  D instr destination register (after regdst/jal select)
d_tnew  input  3  cycles after entering E until result forwardable (ALU=1, lw=2, jal=0)
stall  output  1  hold PC and IF/ID, insert bubble into ID/EX
fwd_d_rs  output  2  D rs source: 0=RF, 1=E, 2=M, 3=W
fwd_d_rt  output  2  same for rt
fwd_e_rs  output  2  E rs source: 0=pipeline reg, 1=M, 2=W
fwd_e_rt  output  2  same for rt
stall_cnt  output  CNT_W  count of stalled cycles, wraps

Behaviour:
- Slots E, M, W each hold: w (write valid), dst[4:0], tnew[2:0]. Slot E also holds rs[4:0] and rt[4:0].
- A slot with dst==0 is treated as w=0 for every match. $0 never stalls and never forwards.
- Reset (reset==0, async): all slots cleared (w=0, fields 0), stall_cnt=0.
- Combinational outputs after reset: stall=0, all fwd=0.
- Match: slot X matches source r when X.w && X.dst==r && r!=0.
- stall = d_valid && (S(rs) || S(rt)).
  - S(r) = (E matches r && E.tnew > tuse) || (M matches r && M.tnew > tuse).
  - W never stalls: its tnew is always 0.
  - Purely combinational, same cycle as the D inputs.
- Every rising edge, all slots advance:
  - W <= M.
  - M <= E, with tnew = sat(E.tnew-1), sat floors at 0.
  - E <= D fields when !stall && d_valid && d_regw. Otherwise E gets a bubble (w=0). The E.rs/rt copies load d_rs/d_rt when !stall && d_valid, else 0.
  - W.tnew = sat(M.tnew-1).
- Forwarding for D operand r, youngest match wins, E > M > W:
  - Youngest matching slot has tnew==0: select that slot's code.
  - Youngest matching slot has tnew>0: select 0. An older slot is never forwarded past a younger pending writer.
- Forwarding for E operand (E.rs/E.rt), same youngest-wins rule:
  - M matches and M.tnew==0: 1.
  - Else W matches: 2.
  - Else 0.
- stall_cnt increments by 1 on every edge where stall==1. Wraps at 2^CNT_W.
- Simultaneous rs and rt hazards: stall is simply asserted; no priority issue.
- A stalled instruction re-evaluates each cycle as the producer advances.
- Reset mid-stall: slots clear immediately, stall deasserts asynchronously.
- d_valid=0: no stall, D fields ignored, E receives a bubble.

Test Plan:
- lw $8 (tnew 2) then addu using rs=$8 (tuse 1):
  - Required: stall=1 exactly 1 cycle, then fwd_e_rs=2 (W) when addu reaches E, stall_cnt=1.
- addu $9 (tnew 1) then beq rs=$9 (tuse 0):
  - Required: stall 1 cycle.
  - Next cycle fwd_d_rs=2 (M).
- jal (dst $31, tnew 0) then jr $31 (tuse 0):
  - Required: no stall, fwd_d_rs=1 (E).
- Writer to $0 (lw $0) followed by addu rs=$0:
  - Required: stall=0, all fwd=0.
- ori $5 in M (tnew 0) and lw $5 in E (tnew 2), consumer sw rt=$5 (tuse 3, unused):
  - Required: stall=0, fwd_d_rt=0 (younger pending writer blocks M forward).
- Assert reset low while stall=1 after lw hazard:
  - Required: stall drops immediately, stall_cnt=0.
  - Slots empty after release: a following addu reading $8 gets fwd=0.
